// File: rtl/rs485_tx_sched_if.sv
// Bundle of the requester handshakes, the raw bus receive line and the
// uart_tx / transceiver controls that surround rs485_tx_sched.
// master: the surrounding system (requesters, line, serializer).
// slave : the scheduler itself.
interface rs485_tx_sched_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       rs485_uart_rxd;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       rs485_de;
    logic       busy;

    modport master (
        output req0_valid,
        output req0_data,
        input  req0_ready,
        output req1_valid,
        output req1_data,
        input  req1_ready,
        output rs485_uart_rxd,
        input  uart_tx_en,
        input  uart_tx_data,
        input  rs485_de,
        input  busy
    );

    modport slave (
        input  req0_valid,
        input  req0_data,
        output req0_ready,
        input  req1_valid,
        input  req1_data,
        output req1_ready,
        input  rs485_uart_rxd,
        output uart_tx_en,
        output uart_tx_data,
        output rs485_de,
        output busy
    );
endinterface

// File: rtl/rs485_tx_sched.sv
// Half-duplex RS485 transmit scheduler.
// Round-robin arbitration between two byte requesters, waits for the bus to
// be idle for IDLE_BITS bit times, then frames each byte with a one-bit
// driver-enable lead-in and a GUARD_BITS guard after the last stop bit.
// Back-to-back bytes keep DE asserted and skip both lead-in and guard.
// GUARD_BITS is expected to be at least 1.
module rs485_tx_sched #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int IDLE_BITS  = 11,
    parameter int GUARD_BITS = 2
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    rs485_tx_sched_if.slave bus
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
    localparam int LEAD_CYC  = BPS_CNT;
    localparam int FRAME_CYC = 10 * BPS_CNT;
    localparam int GUARD_CYC = GUARD_BITS * BPS_CNT;
    localparam int IDLE_CYC  = IDLE_BITS * BPS_CNT;

    // The phase counter serves LEAD, FRAME and GUARD, so size it for the longest.
    localparam int PH_MAX_A  = (LEAD_CYC > FRAME_CYC) ? LEAD_CYC : FRAME_CYC;
    localparam int PH_MAX    = (PH_MAX_A > GUARD_CYC) ? PH_MAX_A : GUARD_CYC;
    localparam int PH_W      = $clog2(PH_MAX + 1);
    localparam int IDLE_W    = $clog2(IDLE_CYC + 1);

    localparam logic [PH_W-1:0]   LEAD_LAST  = PH_W'(LEAD_CYC - 1);
    localparam logic [PH_W-1:0]   FRAME_LAST = PH_W'(FRAME_CYC - 1);
    localparam logic [PH_W-1:0]   GUARD_LAST = PH_W'(GUARD_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT   = IDLE_W'(IDLE_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_START,
        ST_FRAME,
        ST_GUARD
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state;
    logic [PH_W-1:0]     phase;
    logic                last_gnt;      // 1 = requester 1 won the last contest
    logic                tx_en_q;
    logic [7:0]          tx_data_q;
    logic                de_q;

    logic                rxd_meta;
    logic                rxd_sync;
    logic [IDLE_W-1:0]   idle_cnt;

    // Combinational decode
    logic                bus_free;
    logic                any_valid;
    logic                win1;
    logic                phase_last;
    logic                grant;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous receive line; resets to the
    // idle (high) level so the bus does not look active after reset.
    // ------------------------------------------------------------------
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= bus.rs485_uart_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // ------------------------------------------------------------------
    // Idle counter: counts continuous high line time while we are not
    // driving; our own echo is ignored by clearing while DE is high.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idle_cnt <= '0;
        end else if (de_q || !rxd_sync) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_SAT) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign bus_free = (idle_cnt == IDLE_SAT);

    // ------------------------------------------------------------------
    // Arbitration and grant decode from registered state and counters.
    // ------------------------------------------------------------------
    // NOTE: every variable written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        any_valid  = bus.req0_valid | bus.req1_valid;
        // Requester 1 wins if it is alone, or if both ask and 0 won last time.
        win1       = bus.req1_valid & (~bus.req0_valid | ~last_gnt);
        phase_last = 1'b0;
        case (state)
            ST_LEAD:  phase_last = (phase == LEAD_LAST);
            ST_FRAME: phase_last = (phase == FRAME_LAST);
            ST_GUARD: phase_last = (phase == GUARD_LAST);
            default:  phase_last = 1'b0;
        endcase
        grant = any_valid & (((state == ST_IDLE) & bus_free) |
                             ((state == ST_FRAME) & phase_last));
    end

    assign bus.req0_ready   = grant & ~win1;
    assign bus.req1_ready   = grant &  win1;
    assign bus.uart_tx_en   = tx_en_q;
    assign bus.uart_tx_data = tx_data_q;
    assign bus.rs485_de     = de_q;
    assign bus.busy         = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Frame sequencer: IDLE -> LEAD -> START -> FRAME -> (START | GUARD) -> IDLE
    // with registered DE, start pulse and data latch.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            phase     <= '0;
            last_gnt  <= 1'b1;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            de_q      <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;

            // Data and pointer move only on the grant edge.
            if (grant) begin
                tx_data_q <= win1 ? bus.req1_data : bus.req0_data;
                last_gnt  <= win1;
            end

            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        de_q  <= 1'b1;
                        phase <= '0;
                        state <= ST_LEAD;
                    end
                end

                ST_LEAD: begin
                    if (phase_last) begin
                        phase   <= '0;
                        tx_en_q <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end

                ST_START: begin
                    phase <= '0;
                    state <= ST_FRAME;
                end

                ST_FRAME: begin
                    if (phase_last) begin
                        phase <= '0;
                        if (grant) begin
                            // Chain the next byte straight away, DE stays high.
                            tx_en_q <= 1'b1;
                            state   <= ST_START;
                        end else begin
                            state <= ST_GUARD;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end

                ST_GUARD: begin
                    if (phase_last) begin
                        phase <= '0;
                        de_q  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end

                default: begin
                    phase <= '0;
                    de_q  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs485_tx_sched.sv
// Self-checking bench for rs485_tx_sched with BPS_CNT = 10.
// Requesters are modelled as byte queues; a round-robin queue model predicts
// grant order and data, timing is predicted from the frame arithmetic.
module tb_rs485_tx_sched;

    localparam int CLK_FREQ = 1000;
    localparam int UART_BPS = 100;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int FRAME    = 10 * BPS;
    localparam int GUARD    = 2 * BPS;
    localparam int IDLE     = 11 * BPS;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;

    rs485_tx_sched_if bus ();

    rs485_tx_sched #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .IDLE_BITS (11),
        .GUARD_BITS(2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic       smp_r0, smp_r1, smp_en, smp_de, smp_busy;
    logic [7:0] smp_data;
    logic       prev_de  = 1'b0;
    logic       prev_rdy = 1'b0;
    int de_falls = 0, de_rises = 0, ready_cnt = 0, both_viol = 0, consec_viol = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         gnt_who[$];
    bit         exp_who[$];
    logic [7:0] exp_data[$];
    bit         model_last = 1'b1;
    int         last_fall  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_producers();
        bus.req0_valid = (q0.size() != 0);
        bus.req0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
        bus.req1_valid = (q1.size() != 0);
        bus.req1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    // One clock: sample outputs at the falling edge, update requesters just
    // after the rising edge that consumed any ready.
    task automatic step();
        @(negedge sys_clk);
        cyc++;
        smp_r0   = bus.req0_ready;
        smp_r1   = bus.req1_ready;
        smp_en   = bus.uart_tx_en;
        smp_de   = bus.rs485_de;
        smp_busy = bus.busy;
        smp_data = bus.uart_tx_data;
        if (smp_r0 && smp_r1) both_viol++;
        if ((smp_r0 || smp_r1) && prev_rdy) consec_viol++;
        if (smp_r0 || smp_r1) ready_cnt++;
        if (smp_r0) gnt_who.push_back(1'b0);
        if (smp_r1) gnt_who.push_back(1'b1);
        if (prev_de && !smp_de) de_falls++;
        if (!prev_de && smp_de) de_rises++;
        prev_de  = smp_de;
        prev_rdy = smp_r0 | smp_r1;
        @(posedge sys_clk);
        #1;
        if (smp_r0 && q0.size() != 0) void'(q0.pop_front());
        if (smp_r1 && q1.size() != 0) void'(q1.pop_front());
        drive_producers();
    endtask

    task automatic wait_ready(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            step();
            if (smp_r0 || smp_r1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_en(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            step();
            if (smp_en) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_de_low(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            step();
            if (!smp_de) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Round-robin over the pending byte queues: when both have bytes, the one
    // that did not win last goes first; a lone requester always wins.
    task automatic predict();
        logic [7:0] c0[$];
        logic [7:0] c1[$];
        bit         pick1;
        c0 = q0;
        c1 = q1;
        exp_who.delete();
        exp_data.delete();
        while (c0.size() != 0 || c1.size() != 0) begin
            pick1 = (c1.size() != 0) && (c0.size() == 0 || model_last == 1'b0);
            exp_who.push_back(pick1);
            exp_data.push_back(pick1 ? c1.pop_front() : c0.pop_front());
            model_last = pick1;
        end
    endtask

    // Asserts reset just after a rising edge and checks outputs fall without
    // waiting for a clock; returns the cycle index at release.
    task automatic apply_reset(output int r);
        sys_rst_n = 1'b0;
        #1;
        check("rst de",    bus.rs485_de,     0);
        check("rst en",    bus.uart_tx_en,   0);
        check("rst data",  bus.uart_tx_data, 8'h00);
        check("rst rdy0",  bus.req0_ready,   0);
        check("rst rdy1",  bus.req1_ready,   0);
        check("rst busy",  bus.busy,         0);
        repeat (3) step();
        sys_rst_n  = 1'b1;
        r          = cyc;
        model_last = 1'b1;
    endtask

    // Observes one DE window carrying exp_who/exp_data. exp_gnt < 0 skips the
    // grant-time check; guard_push >= 0 injects a requester-0 byte 5 cycles
    // into GUARD and checks it is not granted before DE falls.
    task automatic run_burst(input string tag, input int exp_gnt, input int guard_push);
        int g, e, prev_e, d, falls0, rdy0, n, m;
        n      = exp_who.size();
        gnt_who.delete();
        falls0 = de_falls;
        prev_e = -1;
        rdy0   = 0;
        wait_ready(IDLE + 400, g);
        if (exp_gnt >= 0) check({tag, " grant cycle"}, g, exp_gnt);
        step();
        check({tag, " de rise"}, smp_de, 1);
        for (int k = 0; k < n; k++) begin
            wait_en(FRAME + BPS + 20, e);
            check({tag, " tx data"}, smp_data, exp_data[k]);
            if (k == 0) check({tag, " lead"}, e - g, BPS + 1);
            else        check({tag, " spacing"}, e - prev_e, FRAME + 1);
            prev_e = e;
        end
        if (guard_push >= 0) begin
            while (cyc < prev_e + FRAME + 5) step();
            q0.push_back(guard_push[7:0]);
            drive_producers();
            rdy0 = ready_cnt;
        end
        wait_de_low(FRAME + GUARD + 50, d);
        check({tag, " de fall"}, d - prev_e, FRAME + GUARD + 1);
        if (guard_push >= 0) check({tag, " guard no grant"}, ready_cnt - rdy0, 0);
        check({tag, " de drops"}, de_falls - falls0, 1);
        check({tag, " grant count"}, gnt_who.size(), n);
        m = (gnt_who.size() < n) ? gnt_who.size() : n;
        for (int k = 0; k < m; k++) check({tag, " grant who"}, gnt_who[k], exp_who[k]);
        last_fall = d;
    endtask

    initial begin
        int r, c, g, e, rdy0, rise0, n0, n1;

        // Power-up with a byte already waiting and the line idle.
        bus.rs485_uart_rxd = 1'b1;
        q0.push_back(8'hA5);
        drive_producers();
        #2;
        apply_reset(r);

        // First byte: grant after the full idle window, then lead, frame, guard.
        predict();
        run_burst("first", r + 1 + IDLE, -1);

        // A valid that goes away before the bus is free leaves no trace.
        rdy0 = ready_cnt;
        q0.push_back(8'h3C);
        drive_producers();
        repeat (3) step();
        q0.delete();
        drive_producers();
        repeat (10) step();
        check("pulse no ready", ready_cnt - rdy0, 0);
        check("pulse data held", smp_data, 8'hA5);
        check("pulse busy", smp_busy, 0);

        // A request arriving during GUARD waits for a fresh idle window.
        q0.push_back(8'h5A);
        drive_producers();
        predict();
        run_burst("guard", last_fall + IDLE, 'hC3);
        predict();
        run_burst("after guard", last_fall + IDLE, -1);

        // Line activity every 50 cycles keeps the bus busy.
        q1.push_back(8'h7E);
        drive_producers();
        rdy0  = ready_cnt;
        rise0 = de_rises;
        c     = cyc;
        for (int p = 0; p < 4; p++) begin
            bus.rs485_uart_rxd = 1'b0;
            c = cyc;
            step();
            bus.rs485_uart_rxd = 1'b1;
            repeat (49) step();
        end
        check("rxd no ready", ready_cnt - rdy0, 0);
        check("rxd de quiet", de_rises - rise0, 0);
        // Low captured at edge c+1, synchronized at c+2, counter cleared at c+3.
        predict();
        run_burst("rxd", c + 4 + IDLE, -1);

        // Both requesters continuously valid from reset.
        apply_reset(r);
        q0.push_back(8'h01);
        q0.push_back(8'h01);
        q1.push_back(8'h02);
        q1.push_back(8'h02);
        drive_producers();
        predict();
        run_burst("rr", r + 1 + IDLE, -1);

        // Randomized request mixes against the queue model.
        for (int round = 0; round < 3; round++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
            for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
            drive_producers();
            predict();
            run_burst("rand", last_fall + IDLE, -1);
        end

        // Reset in the middle of a frame with a request still held.
        q0.push_back(8'h96);
        drive_producers();
        predict();
        wait_ready(IDLE + 50, g);
        check("mid grant cycle", g, last_fall + IDLE);
        wait_en(BPS + 20, e);
        check("mid tx data", smp_data, 8'h96);
        while (cyc < e + 30) step();
        q0.push_back(8'h69);
        drive_producers();
        apply_reset(r);
        predict();
        run_burst("post rst", r + 1 + IDLE, -1);

        check("both ready", both_viol, 0);
        check("ready twice", consec_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
